// File: rtl/soc_system_sysid_reader.sv
// rtl/soc_system_sysid_reader.sv - reads and checks the system ID and build timestamp over Avalon-MM
//
// Purpose: after reset (when AUTO_START=1) or on a start pulse, reads word 0
// (system ID) and then word 1 (build timestamp) from an Avalon-MM slave. It
// captures both words and reports whether they match EXPECTED_ID and
// EXPECTED_TS. An access that stalls for TIMEOUT waitrequest cycles ends the
// check with error=1.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   start                 single-cycle pulse that requests a new check
//   avm_address/avm_read  master address (0 = ID, 1 = timestamp) and read strobe
//   avm_waitrequest       slave stall
//   avm_readdata          slave read data
//   id_value              captured ID word
//   timestamp_value       captured timestamp word
//   busy, done            check in progress, check finished (held until next start)
//   id_ok, error          both words matched, access timed out (valid when done=1)
module soc_system_sysid_reader #(
  parameter logic [31:0] EXPECTED_ID  = 32'd4368,
  parameter logic [31:0] EXPECTED_TS  = 32'd1546432878,
  parameter int          READ_LATENCY = 0,
  parameter int          TIMEOUT      = 255,
  parameter int          AUTO_START   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, REQ, LAT, DONE} state_t;

  localparam int          LAT_LAST_I   = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  localparam logic [1:0]  LAT_LAST     = 2'(LAT_LAST_I);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        addr_q, addr_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        error_q, error_d;
  // Remembers that the automatic post-reset check has been launched.
  logic        auto_done_q, auto_done_d;
  logic        capture;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wait_cnt_d  = wait_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    id_d        = id_q;
    ts_d        = ts_q;
    done_d      = done_q;
    id_ok_d     = id_ok_q;
    error_d     = error_q;
    auto_done_d = auto_done_q;
    capture     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start || (state_q == IDLE && AUTO_START != 0 && !auto_done_q)) begin
          state_d     = REQ;
          addr_d      = 1'b0;
          wait_cnt_d  = '0;
          done_d      = 1'b0;
          id_ok_d     = 1'b0;
          error_d     = 1'b0;
          auto_done_d = 1'b1;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            capture = 1'b1;
          end else begin
            state_d   = LAT;
            lat_cnt_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
          // The edge that brings the counter to TIMEOUT ends the check.
          if (wait_cnt_q == TIMEOUT_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            error_d = 1'b1;
            id_ok_d = 1'b0;
          end
        end
      end
      LAT: begin
        // lat_cnt_q counts edges already spent after acceptance; data is
        // taken on the READ_LATENCY-th edge.
        if (lat_cnt_q == LAT_LAST) begin
          capture = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      if (!addr_q) begin
        // ID captured: go straight on to the timestamp access.
        id_d       = avm_readdata;
        addr_d     = 1'b1;
        state_d    = REQ;
        wait_cnt_d = '0;
      end else begin
        ts_d    = avm_readdata;
        state_d = DONE;
        done_d  = 1'b1;
        error_d = 1'b0;
        id_ok_d = (id_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 1'b0;
      wait_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      id_q        <= '0;
      ts_q        <= '0;
      done_q      <= 1'b0;
      id_ok_q     <= 1'b0;
      error_q     <= 1'b0;
      auto_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wait_cnt_q  <= wait_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      id_q        <= id_d;
      ts_q        <= ts_d;
      done_q      <= done_d;
      id_ok_q     <= id_ok_d;
      error_q     <= error_d;
      auto_done_q <= auto_done_d;
    end
  end

  assign avm_address     = addr_q;
  assign avm_read        = (state_q == REQ);
  assign busy            = (state_q == REQ) || (state_q == LAT);
  assign done            = done_q;
  assign id_ok           = id_ok_q;
  assign error           = error_q;
  assign id_value        = id_q;
  assign timestamp_value = ts_q;

endmodule

// File: tb/tb_soc_system_sysid_reader.sv
// tb/tb_soc_system_sysid_reader.sv - directed self-checking bench for soc_system_sysid_reader
module tb_soc_system_sysid_reader;

  localparam logic [31:0] ID_W = 32'd4368;
  localparam logic [31:0] TS_W = 32'd1546432878;

  logic clock;
  logic reset;

  // dut0: zero latency, TIMEOUT=15, auto start
  logic        start0, addr0, read0, wait0, busy0, done0, id_ok0, error0;
  logic [31:0] rdata0, id0, ts0, id_word, ts_word;

  // dut2: READ_LATENCY=2, no auto start
  logic        start2, addr2, read2, wait2, busy2, done2, id_ok2, error2;
  logic [31:0] rdata2, id2, ts2;
  logic        s1_v, s1_a, s2_v, s2_a;

  int checks;
  int errors;

  soc_system_sysid_reader #(
    .READ_LATENCY(0), .TIMEOUT(15), .AUTO_START(1)
  ) dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wait0),
    .avm_readdata(rdata0), .id_value(id0), .timestamp_value(ts0),
    .busy(busy0), .done(done0), .id_ok(id_ok0), .error(error0)
  );

  soc_system_sysid_reader #(
    .READ_LATENCY(2), .TIMEOUT(255), .AUTO_START(0)
  ) dut2 (
    .clock(clock), .reset(reset), .start(start2),
    .avm_address(addr2), .avm_read(read2), .avm_waitrequest(wait2),
    .avm_readdata(rdata2), .id_value(id2), .timestamp_value(ts2),
    .busy(busy2), .done(done2), .id_ok(id_ok2), .error(error2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Zero-latency slave: data valid in the same cycle as the read.
  assign rdata0 = addr0 ? ts_word : id_word;

  // Two-cycle latency slave: garbage on the bus except in the cycle
  // two edges after acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0; s1_a <= 1'b0; s2_v <= 1'b0; s2_a <= 1'b0;
    end else begin
      s1_v <= read2 && !wait2;
      s1_a <= addr2;
      s2_v <= s1_v;
      s2_a <= s1_a;
    end
  end
  assign rdata2 = s2_v ? (s2_a ? TS_W : ID_W) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start0 = 1'b0; start2 = 1'b0; wait0 = 1'b0; wait2 = 1'b0;
    id_word = ID_W; ts_word = TS_W;

    @(negedge clock); #1;
    chk("rst_read0", {31'd0, read0}, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    chk("rst_done0", {31'd0, done0}, 32'd0);
    chk("rst_id0", id0, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);

    // Zero-wait check launched automatically after reset release.
    @(negedge clock); reset = 1'b0;
    tick();
    chk("auto_read", {31'd0, read0}, 32'd1);
    chk("auto_addr0", {31'd0, addr0}, 32'd0);
    chk("auto_busy", {31'd0, busy0}, 32'd1);
    tick();
    chk("zw_read_a1", {30'd0, read0, addr0}, 32'd3);
    chk("zw_id", id0, ID_W);
    tick();
    chk("zw_done", {28'd0, done0, id_ok0, error0, read0}, 32'b1100);
    chk("zw_ts", ts0, TS_W);
    chk("noauto_busy2", {30'd0, busy2, read2}, 32'd0);

    // Three waitrequest cycles on the ID access.
    wait0 = 1'b1; start0 = 1'b1;
    tick(); start0 = 1'b0;
    chk("ws_c1", {29'd0, done0, read0, addr0}, 32'b010);
    tick(); chk("ws_c2", {30'd0, read0, addr0}, 32'b10);
    tick(); chk("ws_c3", {30'd0, read0, addr0}, 32'b10);
    tick(); chk("ws_c4", {30'd0, read0, addr0}, 32'b10);
    wait0 = 1'b0;
    tick(); chk("ws_a1", {30'd0, read0, addr0}, 32'b11);
    tick(); chk("ws_done", {29'd0, done0, id_ok0, error0}, 32'b110);

    // Bad timestamp; start while busy must be ignored.
    ts_word = 32'd0; start0 = 1'b1;
    tick(); start0 = 1'b0;
    chk("bt_cleared", {30'd0, done0, id_ok0}, 32'd0);
    tick();
    chk("bt_a1", {30'd0, read0, addr0}, 32'b11);
    start0 = 1'b1;
    tick(); start0 = 1'b0;
    chk("bt_done", {28'd0, done0, id_ok0, error0, read0}, 32'b1000);
    chk("bt_ts", ts0, 32'd0);
    chk("bt_id", id0, ID_W);

    // Stuck waitrequest, TIMEOUT=15.
    ts_word = TS_W; wait0 = 1'b1; start0 = 1'b1;
    id_word = 32'h1234_5678;
    tick(); start0 = 1'b0;
    chk("to_c0", {30'd0, read0, done0}, 32'b10);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk($sformatf("to_c%0d", i), {30'd0, read0, done0}, 32'b10);
    end
    tick();
    chk("to_done", {27'd0, done0, error0, id_ok0, read0, busy0}, 32'b11000);
    chk("to_id_kept", id0, ID_W);
    tick();
    chk("to_read_off", {31'd0, read0}, 32'd0);

    id_word = ID_W; wait0 = 1'b0; start0 = 1'b1;
    tick(); start0 = 1'b0;
    chk("rec_err_clr", {31'd0, error0}, 32'd0);
    tick(); tick();
    chk("rec_done", {29'd0, done0, id_ok0, error0}, 32'b110);

    // READ_LATENCY=2: data valid only two edges after acceptance.
    start2 = 1'b1;
    tick(); start2 = 1'b0;
    chk("l2_req", {29'd0, busy2, read2, addr2}, 32'b110);
    tick();
    chk("l2_lat", {30'd0, busy2, read2}, 32'b10);
    chk("l2_no_early", id2, 32'd0);
    tick();
    chk("l2_no_stale", id2, 32'd0);
    tick();
    chk("l2_id", id2, ID_W);
    chk("l2_a1", {30'd0, read2, addr2}, 32'b11);
    tick(); tick(); tick();
    chk("l2_done", {29'd0, done2, id_ok2, error2}, 32'b110);
    chk("l2_ts", ts2, TS_W);

    // Reset in the middle of LAT.
    start2 = 1'b1;
    tick(); start2 = 1'b0;
    tick();
    chk("rl_in_lat", {30'd0, busy2, read2}, 32'b10);
    reset = 1'b1; #1;
    chk("rl_busy2", {30'd0, busy2, done2}, 32'd0);
    chk("rl_id2", id2, 32'd0);
    chk("rl_ts2", ts2, 32'd0);
    chk("rl_done0", {29'd0, done0, id_ok0, read0}, 32'd0);
    @(negedge clock); reset = 1'b0;
    tick();
    chk("rl_idle2", {30'd0, busy2, read2}, 32'd0);
    chk("rl_auto0", {30'd0, read0, addr0}, 32'b10);
    start2 = 1'b1;
    tick(); start2 = 1'b0;
    chk("rl_restart", {30'd0, read2, addr2}, 32'b10);
    tick();
    start2 = 1'b1;
    tick(); start2 = 1'b0;
    tick();
    chk("rl_ignored", {30'd0, read2, addr2}, 32'b11);
    tick(); tick(); tick();
    chk("rl_done", {29'd0, done2, id_ok2, error2}, 32'b110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
